// File: rtl/cpu_cycle_ctrl.sv
// CPU execution controller: stretched reset, run/halt/N-cycle step via clock enable, cycle counter.
// Optional breakpoint halt enabled by defining CPU_CYCLE_BREAK_EN.
`timescale 1ns/1ps
module cpu_cycle_ctrl #(
   parameter int RST_CYCLES = 4,
   parameter int CW         = 16,
   parameter int AUTO_RUN   = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run_req,
   input  logic          halt_req,
   input  logic          step_req,
   input  logic [CW-1:0] step_n,
   input  logic [CW-1:0] bp_cycle,
   output logic          cpu_rst_n,
   output logic          cpu_en,
   output logic [1:0]    state,
   output logic [CW-1:0] cycle_cnt,
   output logic          bp_hit
);

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      HALTED   = 2'd1,
      RUNNING  = 2'd2,
      STEPPING = 2'd3
   } state_t;

   localparam logic [7:0]    HOLD_LAST = 8'(RST_CYCLES - 1);
   localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};

   state_t        st;
   logic [7:0]    hold_cnt;
   logic [CW-1:0] remain;
   logic [CW-1:0] cnt_nxt;
   logic          bp_match;

   assign cpu_en  = (st == RUNNING) || (st == STEPPING);
   assign state   = st;
   assign cnt_nxt = cycle_cnt + ONE;

`ifdef CPU_CYCLE_BREAK_EN
   assign bp_match = cpu_en && (cnt_nxt == bp_cycle);
`else
   logic unused_bp;
   assign unused_bp = ^bp_cycle;
   assign bp_match  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= RST_HOLD;
         cpu_rst_n <= 1'b0;
         cycle_cnt <= '0;
         bp_hit    <= 1'b0;
         hold_cnt  <= '0;
         remain    <= '0;
      end else begin
         bp_hit <= 1'b0;
         if (cpu_en) cycle_cnt <= cnt_nxt;
         case (st)
            RST_HOLD: begin
               if (hold_cnt == HOLD_LAST) begin
                  cpu_rst_n <= 1'b1;
                  st        <= (AUTO_RUN != 0) ? RUNNING : HALTED;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            HALTED: begin
               // halt_req outranks the others even here: it simply keeps us halted
               if (halt_req) begin
                  st <= HALTED;
               end else if (step_req) begin
                  remain <= (step_n == '0) ? ONE : step_n;
                  st     <= STEPPING;
               end else if (run_req) begin
                  st <= RUNNING;
               end
            end
            RUNNING: begin
               if (halt_req || bp_match) begin
                  st     <= HALTED;
                  bp_hit <= bp_match;
               end
            end
            STEPPING: begin
               if (halt_req || bp_match || remain == ONE) begin
                  st     <= HALTED;
                  remain <= '0;
                  bp_hit <= bp_match;
               end else begin
                  remain <= remain - ONE;
               end
            end
            default: st <= RST_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
// Scoreboard bench for cpu_cycle_ctrl: expectations queued with stimulus, popped when results are observed.
`timescale 1ns/1ps
module tb_cpu_cycle_ctrl;

   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run_req, halt_req, step_req;
   logic [CW-1:0] step_n, bp_cycle;
   logic          cpu_rst_n, cpu_en, bp_hit;
   logic [1:0]    state;
   logic [CW-1:0] cycle_cnt;

   int checks = 0;
   int failures = 0;
   int en_cycles = 0;
   int bp_pulses = 0;
   bit mon_clr = 1'b0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t exp_q[$];

   cpu_cycle_ctrl #(.RST_CYCLES(4), .CW(CW), .AUTO_RUN(0)) dut (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .step_n(step_n), .bp_cycle(bp_cycle),
      .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .state(state),
      .cycle_cnt(cycle_cnt), .bp_hit(bp_hit)
   );

   always #5 clk = ~clk;

   // Observes the enable and breakpoint pulses mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (mon_clr) begin
         en_cycles = 0;
         bp_pulses = 0;
      end else begin
         if (cpu_en) en_cycles = en_cycles + 1;
         if (bp_hit) bp_pulses = bp_pulses + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks = checks + 1;
      if (obs !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input int obs);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_underflow", obs, -1);
      end else begin
         e = exp_q.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic pulse(input bit r, input bit h, input bit s);
      run_req  = r;
      halt_req = h;
      step_req = s;
      tick();
      run_req  = 1'b0;
      halt_req = 1'b0;
      step_req = 1'b0;
   endtask

   task automatic wait_state(input int val, input int max);
      int n = 0;
      while (int'(state) != val && n < max) begin
         tick();
         n++;
      end
   endtask

   task automatic hold_edges(output int edges);
      edges = 0;
      while (!cpu_rst_n && edges < 20) begin
         tick();
         edges++;
      end
   endtask

   initial begin
      int edges;
      rst_n = 1'b0; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
      step_n = '0; bp_cycle = 16'hFFFF;

      #2;
      sb_push("rst_cpu_rst_n", 0); sb_push("rst_state", 0);
      sb_push("rst_cpu_en", 0);    sb_push("rst_cnt", 0);
      sb_pop(int'(cpu_rst_n)); sb_pop(int'(state)); sb_pop(int'(cpu_en)); sb_pop(int'(cycle_cnt));

      tick(); tick();
      rst_n = 1'b1;
      sb_push("hold_edges", 4); sb_push("hold_state", 1);
      sb_push("hold_cpu_en", 0); sb_push("hold_cnt", 0);
      hold_edges(edges);
      sb_pop(edges); sb_pop(int'(state)); sb_pop(int'(cpu_en)); sb_pop(int'(cycle_cnt));

      // run, halt sampled 10 edges later
      clr_mon();
      sb_push("run_en", 10); sb_push("run_cnt", 10); sb_push("run_state", 1);
      pulse(1, 0, 0);
      repeat (9) tick();
      pulse(0, 1, 0);
      tick();
      sb_pop(en_cycles); sb_pop(int'(cycle_cnt)); sb_pop(int'(state));

      // step 3 then step 0
      clr_mon();
      step_n = 16'd3;
      sb_push("step3_en", 3); sb_push("step3_cnt", 13); sb_push("step3_state", 1);
      pulse(0, 0, 1);
      wait_state(1, 20); tick(); tick();
      sb_pop(en_cycles); sb_pop(int'(cycle_cnt)); sb_pop(int'(state));

      clr_mon();
      step_n = 16'd0;
      sb_push("step0_en", 1); sb_push("step0_cnt", 14);
      pulse(0, 0, 1);
      wait_state(1, 20); tick(); tick();
      sb_pop(en_cycles); sb_pop(int'(cycle_cnt));

      // long step aborted by halt+run together on the 5th edge
      clr_mon();
      step_n = 16'd100;
      sb_push("abort_en", 5); sb_push("abort_cnt", 19); sb_push("abort_state", 1);
      pulse(0, 0, 1);
      repeat (4) tick();
      pulse(1, 1, 0);
      tick(); tick();
      sb_pop(en_cycles); sb_pop(int'(cycle_cnt)); sb_pop(int'(state));

      // step beats run when both arrive in HALTED
      clr_mon();
      step_n = 16'd2;
      sb_push("steprun_en", 2); sb_push("steprun_cnt", 21); sb_push("steprun_state", 1);
      pulse(1, 0, 1);
      wait_state(1, 20); tick(); tick();
      sb_pop(en_cycles); sb_pop(int'(cycle_cnt)); sb_pop(int'(state));

      // halt beats everything in HALTED
      clr_mon();
      sb_push("allreq_en", 0); sb_push("allreq_state", 1); sb_push("allreq_cnt", 21);
      pulse(1, 1, 1);
      tick(); tick();
      sb_pop(en_cycles); sb_pop(int'(state)); sb_pop(int'(cycle_cnt));

      // step_req ignored while running; run on to cycle 37
      sb_push("run_step_ign_state", 2); sb_push("run37_cnt", 37); sb_push("run37_state", 2);
      pulse(1, 0, 0);
      repeat (3) tick();
      pulse(0, 0, 1);
      sb_pop(int'(state));
      for (int i = 0; i < 50 && cycle_cnt != 16'd37; i++) tick();
      sb_pop(int'(cycle_cnt)); sb_pop(int'(state));

      // mid-run reset: immediate clear, then full hold with run_req held (ignored)
      sb_push("mrst_cpu_rst_n", 0); sb_push("mrst_cpu_en", 0);
      sb_push("mrst_cnt", 0);       sb_push("mrst_state", 0);
      rst_n = 1'b0;
      #1;
      sb_pop(int'(cpu_rst_n)); sb_pop(int'(cpu_en)); sb_pop(int'(cycle_cnt)); sb_pop(int'(state));
      rst_n = 1'b1;
      run_req = 1'b1;
      sb_push("mrst_hold_edges", 4); sb_push("mrst_hold_state", 1); sb_push("mrst_hold_cnt", 0);
      hold_edges(edges);
      run_req = 1'b0;
      sb_pop(edges); sb_pop(int'(state)); sb_pop(int'(cycle_cnt));

      // breakpoint at cycle 20
      clr_mon();
      bp_cycle = 16'd20;
`ifdef CPU_CYCLE_BREAK_EN
      sb_push("bp_cnt", 20); sb_push("bp_state", 1); sb_push("bp_pulses", 1);
      pulse(1, 0, 0);
      wait_state(1, 40);
      repeat (3) tick();
`else
      sb_push("nobp_cnt", 25); sb_push("nobp_state", 2); sb_push("nobp_pulses", 0);
      pulse(1, 0, 0);
      repeat (25) tick();
`endif
      sb_pop(int'(cycle_cnt)); sb_pop(int'(state)); sb_pop(bp_pulses);

      chk("sb_leftover", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
